// File: rtl/md5_cand_gen_pkg.sv
// Shared types and BCD helpers for the MD5 candidate generator.
package md5_cand_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DIGITS     = 8;
    localparam int MAX_DIGITS = 16;
    localparam int BCD_MAX_W  = 4 * MAX_DIGITS;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // Callers zero-extend to BCD_MAX_W; zero nibbles are valid and compare neutrally.
    function automatic logic bcd_is_valid(input logic [BCD_MAX_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // A lexicographic nibble compare from the MS digit equals an unsigned compare of the vector.
    function automatic logic bcd_le(input logic [BCD_MAX_W-1:0] a, input logic [BCD_MAX_W-1:0] b);
        return a <= b;
    endfunction

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/md5_cand_gen_bcd_adder.sv
// Combinational DIGITS-digit BCD adder with a single-digit addend.
module bcd_adder
    import md5_cand_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [3:0]          addend,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out
);

    logic [4:0] c;
    logic [4:0] s;

    // Digit plus carry-in never exceeds 18, so one decimal correction suffices.
    always_comb begin
        c   = {1'b0, addend};
        s   = '0;
        sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + c;
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 5'd1;
            end else begin
                c = 5'd0;
            end
            sum[4*i +: 4] = s[3:0];
        end
        carry_out = c[0];
    end

endmodule

// File: rtl/md5_cand_gen.sv
// Walks BCD passwords low..high onto a valid/ready stream for the MD5 engine.
// Optional MS_TIMER_EN adds a millisecond run timer on elapsed_ms.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | presenting candidates
// S_DONE | range exhausted, stopped or rejected; waits for start
module md5_cand_gen
    import md5_cand_pkg::*;
#(
    parameter int DIGITS = md5_cand_pkg::DIGITS,
    parameter int STRIDE = 1,
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [4*DIGITS-1:0] low,
    input  logic [4*DIGITS-1:0] high,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [4*DIGITS-1:0] cand_bcd,
    output logic [8*DIGITS-1:0] cand_ascii,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         count,
    output logic [31:0]         elapsed_ms
);

    localparam int BW = 4 * DIGITS;

    state_t        state, state_nxt;
    logic [BW-1:0] cur, hi, next;
    logic          carry, last, start_ok, range_ok, accept;

    bcd_adder #(.DIGITS(DIGITS)) u_add (
        .a         (cur),
        .addend    (4'(STRIDE)),
        .sum       (next),
        .carry_out (carry)
    );

    assign range_ok = bcd_is_valid(BCD_MAX_W'(low)) && bcd_is_valid(BCD_MAX_W'(high))
                      && bcd_le(BCD_MAX_W'(low), BCD_MAX_W'(high));
    assign accept   = (state == S_RUN) && cand_ready;
    assign last     = (cur == hi) || carry || !bcd_le(BCD_MAX_W'(next), BCD_MAX_W'(hi));
    assign start_ok = start && (state != S_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = range_ok ? S_RUN : S_DONE;
            S_RUN:          if (stop || (accept && last)) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // A stop coinciding with an accept counts the accept but keeps the presented value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= '0;
            hi    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (start_ok) begin
            cur   <= low;
            hi    <= high;
            count <= '0;
            err   <= !range_ok;
        end else if (accept) begin
            if (count != '1) count <= count + 32'd1;
            if (!stop && !last) cur <= next;
        end
    end

    assign cand_valid = (state == S_RUN);
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign cand_bcd   = cur;

    for (genvar g = 0; g < DIGITS; g++) begin : g_ascii
        assign cand_ascii[8*g +: 8] = bcd_to_ascii(cur[4*g +: 4]);
    end

`ifdef MS_TIMER_EN
    localparam int MS_DIV = (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;

    logic [31:0] prescale;
    logic [31:0] ms_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            ms_cnt   <= '0;
        end else if (start_ok) begin
            prescale <= 32'(MS_DIV - 1);
            ms_cnt   <= '0;
        end else if (state == S_RUN) begin
            if (prescale == '0) begin
                prescale <= 32'(MS_DIV - 1);
                ms_cnt   <= ms_cnt + 32'd1;
            end else begin
                prescale <= prescale - 32'd1;
            end
        end
    end

    assign elapsed_ms = ms_cnt;
`else
    assign elapsed_ms = '0;
`endif

endmodule
